// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the pixel
// source / TMDS encoders (slave). h_state/v_state expose the FSMs for debug.
interface video_timing_gen_if #(
  parameter int CW = 12
);
  logic          en;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [1:0]    h_state;
  logic [1:0]    v_state;

  // Handshake: no valid/ready. en is a pixel enable; every output is
  // registered and describes the pixel counted on the last cycle with en=1.
  // The pulse outputs are high for exactly one clk per emitted pixel.
  modport master (
    input  en,
    output de, hsync, vsync, x, y, line_start, frame_start, h_state, v_state
  );

  modport slave (
    output en,
    input  de, hsync, vsync, x, y, line_start, frame_start, h_state, v_state
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal and vertical FSMs plus pixel counters,
// with all outputs registered one enabled clock behind the counters.
module video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW        = 12
) (
  input  logic                clk,
  input  logic                reset,
  video_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter value of each region; the FSM leaves the region on it.
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_LAST   = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_LAST   = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_H_ACT  = 2'd0,
    S_H_FP   = 2'd1,
    S_H_SYNC = 2'd2,
    S_H_BP   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    S_V_ACT  = 2'd0,
    S_V_FP   = 2'd1,
    S_V_SYNC = 2'd2,
    S_V_BP   = 2'd3
  } v_state_t;

  h_state_t      r_h_state;
  v_state_t      r_v_state;
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_h_wrap;
  logic          w_v_wrap;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_state     <= S_H_ACT;
      r_v_state     <= S_V_ACT;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (bus.en) begin
      // Outputs describe the pixel the counters point at before advancing.
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_de          <= (r_h_state == S_H_ACT) && (r_v_state == S_V_ACT);
      r_hsync       <= (r_h_state == S_H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= (r_v_state == S_V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      r_line_start  <= (r_h_cnt == '0);
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);

      if (w_h_wrap) begin
        r_h_cnt <= '0;
      end else begin
        r_h_cnt <= r_h_cnt + CW'(1);
      end

      case (r_h_state)
        S_H_ACT:  if (r_h_cnt == H_ACT_LAST)  r_h_state <= S_H_FP;
        S_H_FP:   if (r_h_cnt == H_FP_LAST)   r_h_state <= S_H_SYNC;
        S_H_SYNC: if (r_h_cnt == H_SYNC_LAST) r_h_state <= S_H_BP;
        S_H_BP:   if (w_h_wrap)               r_h_state <= S_H_ACT;
        default:                              r_h_state <= S_H_ACT;
      endcase

      // Vertical side moves only at the end of a line.
      if (w_h_wrap) begin
        if (w_v_wrap) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + CW'(1);
        end

        case (r_v_state)
          S_V_ACT:  if (r_v_cnt == V_ACT_LAST)  r_v_state <= S_V_FP;
          S_V_FP:   if (r_v_cnt == V_FP_LAST)   r_v_state <= S_V_SYNC;
          S_V_SYNC: if (r_v_cnt == V_SYNC_LAST) r_v_state <= S_V_BP;
          S_V_BP:   if (w_v_wrap)               r_v_state <= S_V_ACT;
          default:                              r_v_state <= S_V_ACT;
        endcase
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.de          = r_de;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.h_state     = r_h_state;
  assign bus.v_state     = r_v_state;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: three timing generators (640x480, a mid-size mode and
// an 8x5 raster) checked every cycle against a pixel-index reference model.
module tb_video_timing_gen;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } out_t;

  typedef struct {
    int   ha, hf, hsw, hb;
    int   va, vf, vsw, vb;
    logic hpol, vpol;
  } cfg_t;

  typedef struct {
    logic en;
    out_t exp;
  } vec_t;

  logic clk;
  logic en_s;
  logic rst_s;

  int   n_checks;
  int   n_fail;
  cfg_t cfg[3];
  int   pos[3];
  out_t exp_o[3];
  out_t g[3];

  video_timing_gen_if #(.CW(12)) if0 ();
  video_timing_gen_if #(.CW(8))  if1 ();
  video_timing_gen_if #(.CW(4))  if2 ();

  assign if0.en = en_s;
  assign if1.en = en_s;
  assign if2.en = en_s;

  video_timing_gen u0 (.clk(clk), .reset(rst_s), .bus(if0));

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(8)
  ) u1 (.clk(clk), .reset(rst_s), .bus(if1));

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CW(4)
  ) u2 (.clk(clk), .reset(rst_s), .bus(if2));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int total(input cfg_t c);
    return (c.ha + c.hf + c.hsw + c.hb) * (c.va + c.vf + c.vsw + c.vb);
  endfunction

  function automatic out_t mk(input logic de, input logic hs, input logic vs,
                              input logic ls, input logic fs, input int x, input int y);
    out_t o;
    o.de = de; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
    o.x = 12'(x); o.y = 12'(y);
    return o;
  endfunction

  function automatic out_t reset_out(input cfg_t c);
    return mk(1'b0, ~c.hpol, ~c.vpol, 1'b0, 1'b0, 0, 0);
  endfunction

  // Pixel p of the frame in raster order -> what the outputs must show.
  function automatic out_t model(input cfg_t c, input int p);
    int   ht;
    int   x;
    int   y;
    logic in_hs;
    logic in_vs;
    ht    = c.ha + c.hf + c.hsw + c.hb;
    x     = p % ht;
    y     = p / ht;
    in_hs = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hsw);
    in_vs = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vsw);
    return mk((x < c.ha) && (y < c.va), in_hs ? c.hpol : ~c.hpol,
              in_vs ? c.vpol : ~c.vpol, x == 0, p == 0, x, y);
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("de=%0b hs=%0b vs=%0b ls=%0b fs=%0b x=%0d y=%0d",
                     o.de, o.hs, o.vs, o.ls, o.fs, o.x, o.y);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {%s} required {%s}", name, $time, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic out_t get0();
    return mk(if0.de, if0.hsync, if0.vsync, if0.line_start, if0.frame_start,
              int'(if0.x), int'(if0.y));
  endfunction

  function automatic out_t get1();
    return mk(if1.de, if1.hsync, if1.vsync, if1.line_start, if1.frame_start,
              int'(if1.x), int'(if1.y));
  endfunction

  function automatic out_t get2();
    return mk(if2.de, if2.hsync, if2.vsync, if2.line_start, if2.frame_start,
              int'(if2.x), int'(if2.y));
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic r);
    @(negedge clk);
    en_s  = e;
    rst_s = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        pos[i]   = 0;
        exp_o[i] = reset_out(cfg[i]);
      end else if (e) begin
        exp_o[i] = model(cfg[i], pos[i]);
        pos[i]   = (pos[i] + 1) % total(cfg[i]);
      end else begin
        exp_o[i].ls = 1'b0;
        exp_o[i].fs = 1'b0;
      end
    end
    #1;
    g[0] = get0();
    g[1] = get1();
    g[2] = get2();
    for (int i = 0; i < 3; i++) check($sformatf("model_u%0d", i), g[i], exp_o[i]);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[11];

  initial begin
    int ls_q[$];
    int fs_q[$];
    int fs1_q[$];
    int de_cnt, hs_cnt, hs_first_x, de_fall_x, de_rise;
    int vs_cnt, vs_first_x, vs_first_y, de_late, ls_cnt;
    int hold_bad, dup_ls;
    logic prev_ls;
    out_t prev;
    logic hit;
    logic e;

    n_checks = 0;
    n_fail   = 0;
    en_s     = 1'b0;
    rst_s    = 1'b1;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{16, 4, 6, 4, 12, 3, 2, 4, 1'b1, 1'b0};
    cfg[2] = '{4, 1, 2, 1, 2, 1, 1, 1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      pos[i]   = 0;
      exp_o[i] = reset_out(cfg[i]);
    end

    // 8x5 raster: first pixels after release, with en gaps
    tbl[0]  = '{1'b1, mk(1, 1, 1, 1, 1, 0, 0)};
    tbl[1]  = '{1'b1, mk(1, 1, 1, 0, 0, 1, 0)};
    tbl[2]  = '{1'b0, mk(1, 1, 1, 0, 0, 1, 0)};
    tbl[3]  = '{1'b1, mk(1, 1, 1, 0, 0, 2, 0)};
    tbl[4]  = '{1'b1, mk(1, 1, 1, 0, 0, 3, 0)};
    tbl[5]  = '{1'b1, mk(0, 1, 1, 0, 0, 4, 0)};
    tbl[6]  = '{1'b1, mk(0, 0, 1, 0, 0, 5, 0)};
    tbl[7]  = '{1'b0, mk(0, 0, 1, 0, 0, 5, 0)};
    tbl[8]  = '{1'b1, mk(0, 0, 1, 0, 0, 6, 0)};
    tbl[9]  = '{1'b1, mk(0, 1, 1, 0, 0, 7, 0)};
    tbl[10] = '{1'b1, mk(1, 1, 1, 1, 0, 0, 1)};

    // reset held with en=1
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1);
      check("reset_hold", g[0], mk(0, 1, 1, 0, 0, 0, 0));
    end

    for (int k = 0; k < 11; k++) begin
      step(tbl[k].en, 1'b0);
      check($sformatf("tbl_%0d", k), g[2], tbl[k].exp);
    end

    // 640x480: line timing over two lines
    do_reset();
    de_cnt = 0; hs_cnt = 0; hs_first_x = -1; de_fall_x = -1; de_rise = -1;
    for (int k = 0; k <= 1600; k++) begin
      step(1'b1, 1'b0);
      if (g[0].ls) ls_q.push_back(k);
      if (g[0].fs) fs_q.push_back(k);
      if (g[0].y == 12'd0) begin
        if (g[0].de) de_cnt++;
        if (!g[0].de && de_fall_x < 0) de_fall_x = int'(g[0].x);
        if (!g[0].hs) begin
          if (hs_cnt == 0) hs_first_x = int'(g[0].x);
          hs_cnt++;
        end
      end
      if (k == 800) de_rise = int'(g[0].de);
    end
    check_int("ls_count", ls_q.size(), 3);
    check_int("ls_period", qget(ls_q, 1), 800);
    check_int("fs_first_cycle", qget(fs_q, 0), 0);
    check_int("fs_count_line", fs_q.size(), 1);
    check_int("de_per_line", de_cnt, 640);
    check_int("hs_width", hs_cnt, 96);
    check_int("hs_first_x", hs_first_x, 656);
    check_int("de_fall_x", de_fall_x, 640);
    check_int("de_rise_line1", de_rise, 1);

    // mid-size mode: frame and vsync timing
    do_reset();
    fs_q.delete();
    vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; de_late = 0; ls_cnt = 0;
    for (int k = 0; k <= 1260; k++) begin
      step(1'b1, 1'b0);
      if (g[1].fs) fs_q.push_back(k);
      if (k < 630) begin
        if (g[1].ls) ls_cnt++;
        if (g[1].de && g[1].y >= 12'd12) de_late++;
        if (!g[1].vs) begin
          if (vs_cnt == 0) begin
            vs_first_x = int'(g[1].x);
            vs_first_y = int'(g[1].y);
          end
          vs_cnt++;
        end
      end
    end
    check_int("fs_count_2frames", fs_q.size(), 3);
    check_int("fs_period", qget(fs_q, 1), 630);
    check_int("vs_width", vs_cnt, 60);
    check_int("vs_first_x", vs_first_x, 0);
    check_int("vs_first_y", vs_first_y, 15);
    check_int("de_blank_lines", de_late, 0);
    check_int("ls_per_frame", ls_cnt, 21);

    // en toggling halves the rate
    do_reset();
    ls_q.delete();
    fs1_q.delete();
    hold_bad = 0; dup_ls = 0; prev_ls = 1'b0; prev = g[0];
    for (int k = 0; k <= 3200; k++) begin
      e = (k % 2 == 0);
      step(e, 1'b0);
      if (g[0].ls) ls_q.push_back(k);
      if (g[1].fs) fs1_q.push_back(k);
      if (g[0].ls && prev_ls) dup_ls++;
      if (!e && ({g[0].de, g[0].hs, g[0].vs, g[0].x, g[0].y} !==
                 {prev.de, prev.hs, prev.vs, prev.x, prev.y})) hold_bad++;
      prev_ls = g[0].ls;
      prev    = g[0];
    end
    check_int("toggle_ls_count", ls_q.size(), 3);
    check_int("toggle_ls_period", qget(ls_q, 1), 1600);
    check_int("toggle_fs_period", qget(fs1_q, 1), 1260);
    check_int("toggle_dup_pulse", dup_ls, 0);
    check_int("toggle_hold", hold_bad, 0);

    // asynchronous reset mid-line
    do_reset();
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      step(1'b1, 1'b0);
      if (g[0].x == 12'd300) hit = 1'b1;
    end
    check_int("reach_x300", int'(hit), 1);
    #2 rst_s = 1'b1;
    #1;
    check("async_rst_u0", get0(), reset_out(cfg[0]));
    check("async_rst_u1", get1(), reset_out(cfg[1]));
    check("async_rst_u2", get2(), reset_out(cfg[2]));
    for (int i = 0; i < 3; i++) begin
      pos[i]   = 0;
      exp_o[i] = reset_out(cfg[i]);
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("restart_pixel0", g[0], mk(1, 1, 1, 1, 1, 0, 0));

    // 8x5 raster: three full frames, then random en and resets
    do_reset();
    fs_q.delete();
    for (int k = 0; k < 120; k++) begin
      step(1'b1, 1'b0);
      if (g[2].fs) fs_q.push_back(k);
    end
    check_int("tiny_fs_count", fs_q.size(), 3);
    check_int("tiny_fs_period", qget(fs_q, 2), 80);
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
